// File: rtl/dmem_access_unit.sv
`timescale 1ns/1ps
// dmem_access_unit
// Load/store unit between the MEM-stage control and a word-organised DMEM.
// Accepts byte/halfword/word loads and stores on byte addresses, sequences
// the DMEM strobes so read and write are never high together, performs
// sub-word stores as read-modify-write and returns sign/zero-extended loads.
// Misaligned requests are rejected with a one-cycle pulse and never touch
// memory.
module dmem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [1:0]  lsu_size,
    input  logic        lsu_unsigned,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_misaligned,
    output logic [31:0] DMEM_address,
    output logic [31:0] DMEM_data_in,
    output logic        DMEM_mem_write,
    output logic        DMEM_mem_read,
    input  logic [31:0] DMEM_data_out
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD     = 3'd1;
    localparam logic [2:0] ST_WR     = 3'd2;
    localparam logic [2:0] ST_RMW_RD = 3'd3;
    localparam logic [2:0] ST_RMW_WR = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // A request is rejected when its size is illegal or the address is not
    // naturally aligned for that size.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] lane);
        logic mis;
        mis = 1'b0;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lane[0];
            SZ_WORD: mis = (lane != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

    // Pick the addressed lane(s) out of a memory word and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[7:0];
        h = word[15:0];
        r = word;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = word[7:0];
        endcase
        if (lane[1]) begin
            h = word[31:16];
        end else begin
            h = word[15:0];
        end
        case (size)
            SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane(s) of the old memory word with store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [15:0] wd,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [31:0] r;
        r = old;
        case (size)
            SZ_BYTE: begin
                case (lane)
                    2'd0:    r = {old[31:8], wd[7:0]};
                    2'd1:    r = {old[31:16], wd[7:0], old[7:0]};
                    2'd2:    r = {old[31:24], wd[7:0], old[15:0]};
                    2'd3:    r = {wd[7:0], old[23:0]};
                    default: r = old;
                endcase
            end
            SZ_HALF: begin
                if (lane[1]) begin
                    r = {wd[15:0], old[15:0]};
                end else begin
                    r = {old[31:16], wd[15:0]};
                end
            end
            default: r = old;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic        busy_r;
    logic        done_r;
    logic [31:0] rdata_r;
    logic        misaligned_r;
    logic [31:0] address_r;
    logic [31:0] data_in_r;
    logic        mem_write_r;
    logic        mem_read_r;

    // Request fields latched at acceptance; upstream may move on afterwards.
    logic [1:0]  lane_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic [15:0] wdata_r;

    logic        misaligned_s;
    logic        accept_s;
    logic        reject_s;

    // Classify the incoming request: accepted, rejected or not sampled.
    always_comb begin
        misaligned_s = is_misaligned(lsu_size, lsu_addr[1:0]);
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        if ((state_r == ST_IDLE) && lsu_req) begin
            accept_s = ~misaligned_s;
            reject_s = misaligned_s;
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Next-state decode for the access sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (!lsu_we) begin
                        state_nxt_s = ST_RD;
                    end else if (lsu_size == SZ_WORD) begin
                        state_nxt_s = ST_WR;
                    end else begin
                        state_nxt_s = ST_RMW_RD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RD:     state_nxt_s = ST_IDLE;
            ST_WR:     state_nxt_s = ST_IDLE;
            ST_RMW_RD: state_nxt_s = ST_RMW_WR;
            ST_RMW_WR: state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Control registers: state, one-hot strobe flops, busy/done/misaligned.
    // Strobes are flops loaded from the next state, so they are a registered
    // decode of the state and drop at once on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            mem_read_r   <= 1'b0;
            mem_write_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            mem_read_r   <= (state_nxt_s == ST_RD) || (state_nxt_s == ST_RMW_RD);
            mem_write_r  <= (state_nxt_s == ST_WR) || (state_nxt_s == ST_RMW_WR);
            done_r       <= (state_r == ST_RD) || (state_r == ST_WR) ||
                            (state_r == ST_RMW_WR);
            misaligned_r <= reject_s;
        end
    end

    // Request latch and DMEM address: captured only on an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_r     <= 2'b00;
            size_r     <= 2'b00;
            unsigned_r <= 1'b0;
            wdata_r    <= 16'h0000;
            address_r  <= 32'h0000_0000;
        end else if (accept_s) begin
            lane_r     <= lsu_addr[1:0];
            size_r     <= lsu_size;
            unsigned_r <= lsu_unsigned;
            wdata_r    <= lsu_wdata[15:0];
            address_r  <= {2'b00, lsu_addr[31:2]};
        end
    end

    // Write word: full store data on a word-store accept, or the merged word
    // captured at the end of the RMW read (this register is the merge word).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_in_r <= 32'h0000_0000;
        end else if (accept_s && lsu_we && (lsu_size == SZ_WORD)) begin
            data_in_r <= lsu_wdata;
        end else if (state_r == ST_RMW_RD) begin
            data_in_r <= store_merge(DMEM_data_out, wdata_r, lane_r, size_r);
        end
    end

    // Load result: updated only when a load read completes, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'h0000_0000;
        end else if (state_r == ST_RD) begin
            rdata_r <= load_extend(DMEM_data_out, lane_r, size_r, unsigned_r);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign lsu_busy       = busy_r;
    assign lsu_done       = done_r;
    assign lsu_rdata      = rdata_r;
    assign lsu_misaligned = misaligned_r;
    assign DMEM_address   = address_r;
    assign DMEM_data_in   = data_in_r;
    assign DMEM_mem_write = mem_write_r;
    assign DMEM_mem_read  = mem_read_r;

endmodule

// File: tb/tb_dmem_access_unit.sv
`timescale 1ns/1ps
// Self-checking bench for dmem_access_unit: a behavioural DMEM, a reference
// memory and a queue of expected completions filled as requests are issued.
module tb_dmem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        lsu_req;
    logic        lsu_we;
    logic [1:0]  lsu_size;
    logic        lsu_unsigned;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic        lsu_busy;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_misaligned;
    logic [31:0] DMEM_address;
    logic [31:0] DMEM_data_in;
    logic        DMEM_mem_write;
    logic        DMEM_mem_read;
    logic [31:0] DMEM_data_out;

    typedef struct packed {
        logic        is_load;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [0:1023];
    logic [31:0] dmem [0:1023] = '{default: 32'h0};
    int          checks = 0;
    int          errors = 0;

    dmem_access_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lsu_req        (lsu_req),
        .lsu_we         (lsu_we),
        .lsu_size       (lsu_size),
        .lsu_unsigned   (lsu_unsigned),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_busy       (lsu_busy),
        .lsu_done       (lsu_done),
        .lsu_rdata      (lsu_rdata),
        .lsu_misaligned (lsu_misaligned),
        .DMEM_address   (DMEM_address),
        .DMEM_data_in   (DMEM_data_in),
        .DMEM_mem_write (DMEM_mem_write),
        .DMEM_mem_read  (DMEM_mem_read),
        .DMEM_data_out  (DMEM_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DMEM: combinational read, synchronous write.
    assign DMEM_data_out = dmem[DMEM_address[9:0]];
    always @(posedge clk) begin
        if (DMEM_mem_write) dmem[DMEM_address[9:0]] <= DMEM_data_in;
    end

    function automatic bit ref_mis(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'b11) || ((size == 2'b01) && addr[0]) ||
               ((size == 2'b10) && (addr[1:0] != 2'b00));
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {addr[1:0], 3'b000};
        if (size == 2'b00) return uns ? (sh & 32'h0000_00FF) : {{24{sh[7]}}, sh[7:0]};
        if (size == 2'b01) return uns ? (sh & 32'h0000_FFFF) : {{16{sh[15]}}, sh[15:0]};
        return word;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] addr,
                                              input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] mask;
        mask = (size == 2'b00) ? 32'h0000_00FF : (size == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        mask = mask << {addr[1:0], 3'b000};
        return (old & ~mask) | ((wdata << {addr[1:0], 3'b000}) & mask);
    endfunction

    // Drive one request through its accept edge; push the expected completion.
    // Entered and left at posedge+1; on return the bench is in cycle 1.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output bit mis);
        exp_t e;
        logic [9:0] idx;
        idx = addr[11:2];
        mis = ref_mis(size, addr);
        lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
        lsu_addr = addr; lsu_wdata = wdata;
        if (!mis) begin
            if (we) begin
                ref_mem[idx] = ref_store(ref_mem[idx], addr, size, wdata);
                e.is_load = 1'b0; e.data = 32'h0;
            end else begin
                e.is_load = 1'b1; e.data = ref_load(ref_mem[idx], addr, size, uns);
            end
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        lsu_req = 1'b0; lsu_we = ~we; lsu_size = 2'b00; lsu_unsigned = ~uns;
        lsu_addr = 32'h0; lsu_wdata = 32'h0;
    endtask

    // Advance until lsu_done or a cycle budget expires; cyc counts from accept.
    task automatic wait_done(output int cyc, output bit seen);
        cyc = 1;
        while (!lsu_done && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        seen = lsu_done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = 2'b00;
        lsu_unsigned = 1'b0; lsu_addr = 32'h0; lsu_wdata = 32'h0;
        #12;
        checks++; if (lsu_busy !== 1'b0 || lsu_done !== 1'b0 || lsu_misaligned !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: busy=%b done=%b mis=%b, required 0 0 0", lsu_busy, lsu_done, lsu_misaligned); end
        checks++; if (lsu_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h, required 0", lsu_rdata); end
        checks++; if (DMEM_address !== 32'h0 || DMEM_data_in !== 32'h0) begin
            errors++; $display("FAIL reset_dmem_bus: addr=%h din=%h, required 0 0", DMEM_address, DMEM_data_in); end
        checks++; if (DMEM_mem_read !== 1'b0 || DMEM_mem_write !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: rd=%b wr=%b, required 0 0", DMEM_mem_read, DMEM_mem_write); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (lsu_busy !== 1'b0 || lsu_done !== 1'b0) begin
            errors++; $display("FAIL reset_release: busy=%b done=%b, required 0 0", lsu_busy, lsu_done); end
    endtask

    task automatic test_word_round_trip();
        bit mis; bit seen; int cyc; exp_t e;
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, mis);
        checks++; if (DMEM_mem_write !== 1'b1 || DMEM_mem_read !== 1'b0 || DMEM_address !== 32'h10 ||
                      DMEM_data_in !== 32'hDEADBEEF || lsu_busy !== 1'b1) begin
            errors++; $display("FAIL word_store_c1: wr=%b rd=%b addr=%h din=%h busy=%b, required 1 0 00000010 deadbeef 1",
                               DMEM_mem_write, DMEM_mem_read, DMEM_address, DMEM_data_in, lsu_busy); end
        wait_done(cyc, seen);
        checks++; if (!seen || cyc != 2 || lsu_busy !== 1'b0) begin
            errors++; $display("FAIL word_store_done: done=%b cycle=%0d busy=%b, required done at cycle 2 with busy 0", seen, cyc, lsu_busy); end
        e = sb_q.pop_front();
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, mis);
        checks++; if (DMEM_mem_read !== 1'b1 || DMEM_mem_write !== 1'b0 || DMEM_address !== 32'h10) begin
            errors++; $display("FAIL word_load_c1: rd=%b wr=%b addr=%h, required 1 0 00000010", DMEM_mem_read, DMEM_mem_write, DMEM_address); end
        wait_done(cyc, seen);
        checks++; if (!seen || cyc != 2) begin
            errors++; $display("FAIL word_load_done: done=%b cycle=%0d, required done at cycle 2", seen, cyc); end
        e = sb_q.pop_front();
        checks++; if (lsu_rdata !== e.data || lsu_rdata !== 32'hDEADBEEF) begin
            errors++; $display("FAIL word_load_data: got %h, required %h", lsu_rdata, e.data); end
    endtask

    task automatic test_byte_rmw();
        bit mis; bit seen; int cyc; exp_t e;
        issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, mis);
        wait_done(cyc, seen);
        e = sb_q.pop_front();
        issue(1'b1, 2'b00, 1'b0, 32'h42, 32'hFFFFFFAA, mis);
        checks++; if (DMEM_mem_read !== 1'b1 || DMEM_mem_write !== 1'b0 || DMEM_address !== 32'h10) begin
            errors++; $display("FAIL rmw_read_phase: rd=%b wr=%b addr=%h, required 1 0 00000010", DMEM_mem_read, DMEM_mem_write, DMEM_address); end
        @(posedge clk); #1;
        checks++; if (DMEM_mem_read !== 1'b0 || DMEM_mem_write !== 1'b1 || DMEM_data_in !== 32'h11AA3344 || lsu_done !== 1'b0) begin
            errors++; $display("FAIL rmw_write_phase: rd=%b wr=%b din=%h done=%b, required 0 1 11aa3344 0",
                               DMEM_mem_read, DMEM_mem_write, DMEM_data_in, lsu_done); end
        @(posedge clk); #1;
        checks++; if (lsu_done !== 1'b1 || DMEM_mem_write !== 1'b0) begin
            errors++; $display("FAIL rmw_done_c3: done=%b wr=%b, required 1 0", lsu_done, DMEM_mem_write); end
        e = sb_q.pop_front();
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, mis);
        wait_done(cyc, seen);
        e = sb_q.pop_front();
        checks++; if (!seen || lsu_rdata !== e.data || lsu_rdata !== 32'h11AA3344) begin
            errors++; $display("FAIL rmw_reload: done=%b got %h, required %h", seen, lsu_rdata, e.data); end
    endtask

    task automatic test_extension();
        logic [1:0]  t_size [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        logic        t_uns  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] t_addr [5] = '{32'h42, 32'h42, 32'h42, 32'h40, 32'h43};
        logic [31:0] t_exp  [5] = '{32'hFFFFFFAA, 32'h000000AA, 32'h000011AA, 32'h00003344, 32'h00000011};
        bit mis; bit seen; int cyc; exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0, mis);
            wait_done(cyc, seen);
            e = sb_q.pop_front();
            checks++; if (!seen || cyc != 2 || lsu_rdata !== t_exp[i] || lsu_rdata !== e.data) begin
                errors++; $display("FAIL extension_%0d: done=%b cycle=%0d got %h, required %h at cycle 2", i, seen, cyc, lsu_rdata, t_exp[i]); end
        end
    endtask

    task automatic test_misaligned();
        logic        t_we   [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  t_size [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] t_addr [3] = '{32'h41, 32'h42, 32'h40};
        bit mis; bit seen; int cyc; exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(t_we[i], t_size[i], 1'b0, t_addr[i], 32'hCAFEF00D, mis);
            checks++; if (lsu_misaligned !== 1'b1 || DMEM_mem_read !== 1'b0 || DMEM_mem_write !== 1'b0 || lsu_busy !== 1'b0) begin
                errors++; $display("FAIL misaligned_c1_%0d: mis=%b rd=%b wr=%b busy=%b, required 1 0 0 0",
                                   i, lsu_misaligned, DMEM_mem_read, DMEM_mem_write, lsu_busy); end
            for (int c = 0; c < 3; c++) begin
                @(posedge clk); #1;
                checks++; if (lsu_done !== 1'b0 || lsu_misaligned !== 1'b0 || DMEM_mem_read !== 1'b0 || DMEM_mem_write !== 1'b0) begin
                    errors++; $display("FAIL misaligned_quiet_%0d: done=%b mis=%b rd=%b wr=%b, required all 0",
                                       i, lsu_done, lsu_misaligned, DMEM_mem_read, DMEM_mem_write); end
            end
        end
        checks++; if (dmem[16] !== 32'h11AA3344) begin
            errors++; $display("FAIL misaligned_mem: word 0x10 is %h, required 11aa3344", dmem[16]); end
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, mis);
        wait_done(cyc, seen);
        e = sb_q.pop_front();
        checks++; if (!seen || lsu_rdata !== e.data) begin
            errors++; $display("FAIL misaligned_reload: got %h, required %h", lsu_rdata, e.data); end
    endtask

    task automatic test_reset_mid_rmw();
        logic [31:0] saved; bit mis; bit seen; int cyc; exp_t e;
        saved = ref_mem[16];
        issue(1'b1, 2'b00, 1'b0, 32'h40, 32'h00000055, mis);
        checks++; if (DMEM_mem_read !== 1'b1) begin
            errors++; $display("FAIL rst_rmw_setup: rd=%b, required 1", DMEM_mem_read); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (DMEM_mem_read !== 1'b0 || DMEM_mem_write !== 1'b0 || lsu_busy !== 1'b0) begin
            errors++; $display("FAIL rst_rmw_drop: rd=%b wr=%b busy=%b, required 0 0 0", DMEM_mem_read, DMEM_mem_write, lsu_busy); end
        ref_mem[16] = saved;
        sb_q.delete();
        @(posedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            checks++; if (lsu_done !== 1'b0 || DMEM_mem_write !== 1'b0) begin
                errors++; $display("FAIL rst_rmw_quiet: done=%b wr=%b, required 0 0", lsu_done, DMEM_mem_write); end
            @(posedge clk); #1;
        end
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, mis);
        wait_done(cyc, seen);
        e = sb_q.pop_front();
        checks++; if (!seen || lsu_rdata !== e.data || lsu_rdata !== 32'h11AA3344) begin
            errors++; $display("FAIL rst_rmw_reload: got %h, required 11aa3344", lsu_rdata); end
    endtask

    task automatic test_busy_protocol();
        bit mis; bit seen; int cyc; exp_t e;
        issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, mis);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_size = 2'b10; lsu_addr = 32'h80; lsu_wdata = 32'h12345678;
        @(posedge clk); #1;
        lsu_req = 1'b0;
        e = sb_q.pop_front();
        checks++; if (lsu_done !== 1'b1 || lsu_rdata !== e.data) begin
            errors++; $display("FAIL busy_load_done: done=%b got %h, required 1 %h", lsu_done, lsu_rdata, e.data); end
        @(posedge clk); #1;
        checks++; if (lsu_busy !== 1'b0 || DMEM_mem_write !== 1'b0 || lsu_done !== 1'b0) begin
            errors++; $display("FAIL busy_ignored: busy=%b wr=%b done=%b, required 0 0 0", lsu_busy, DMEM_mem_write, lsu_done); end
        issue(1'b0, 2'b10, 1'b0, 32'h80, 32'h0, mis);
        wait_done(cyc, seen);
        e = sb_q.pop_front();
        checks++; if (!seen || lsu_rdata !== e.data || lsu_rdata !== 32'h0) begin
            errors++; $display("FAIL busy_not_queued: got %h, required 00000000", lsu_rdata); end
    endtask

    task automatic test_back_to_back();
        logic        t_we   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  t_size [6] = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01};
        logic [31:0] t_addr [6] = '{32'h100, 32'h102, 32'h100, 32'h101, 32'h101, 32'h102};
        bit mis; bit seen; int cyc; int exp_cyc; exp_t e;
        for (int i = 0; i < 6; i++) begin
            issue(t_we[i], t_size[i], 1'b0, t_addr[i], 32'h8765_4321 + i, mis);
            exp_cyc = (t_we[i] && t_size[i] != 2'b10) ? 3 : 2;
            wait_done(cyc, seen);
            e = sb_q.pop_front();
            checks++; if (!seen || cyc != exp_cyc || (e.is_load && lsu_rdata !== e.data)) begin
                errors++; $display("FAIL back_to_back_%0d: done=%b cycle=%0d rdata=%h, required cycle %0d rdata %h",
                                   i, seen, cyc, lsu_rdata, exp_cyc, e.data); end
        end
    endtask

    task automatic test_random();
        bit mis; int cyc; int exp_cyc; exp_t e;
        logic we; logic [1:0] size; logic uns; logic [31:0] addr; logic [31:0] wd;
        for (int n = 0; n < 1000; n++) begin
            we = 1'($urandom_range(0, 1)); size = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1)); addr = $urandom & 32'hFFFF_F07F; wd = $urandom;
            issue(we, size, uns, addr, wd, mis);
            if (mis) begin
                checks++; if (lsu_misaligned !== 1'b1 || DMEM_mem_read !== 1'b0 || DMEM_mem_write !== 1'b0) begin
                    errors++; $display("FAIL rand_mis_%0d: mis=%b rd=%b wr=%b, required 1 0 0", n, lsu_misaligned, DMEM_mem_read, DMEM_mem_write); end
            end else begin
                exp_cyc = (we && size != 2'b10) ? 3 : 2;
                cyc = 1;
                while (!lsu_done && cyc < 8) begin
                    checks++; if (DMEM_mem_read === 1'b1 && DMEM_mem_write === 1'b1) begin
                        errors++; $display("FAIL rand_strobe_excl_%0d: rd=1 wr=1, required never both", n); end
                    @(posedge clk); #1;
                    cyc++;
                end
                e = sb_q.pop_front();
                checks++; if (lsu_done !== 1'b1 || cyc != exp_cyc || (e.is_load && lsu_rdata !== e.data)) begin
                    errors++; $display("FAIL rand_access_%0d: done=%b cycle=%0d rdata=%h, required cycle %0d rdata %h",
                                       n, lsu_done, cyc, lsu_rdata, exp_cyc, e.data); end
            end
        end
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            checks++; if (dmem[i] !== ref_mem[i]) begin
                errors++; $display("FAIL rand_mem_%0d: got %h, required %h", i, dmem[i], ref_mem[i]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_word_round_trip();
        test_byte_rmw();
        test_extension();
        test_misaligned();
        test_reset_mid_rmw();
        test_busy_protocol();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Load/store unit between the MEM-stage pipeline control and the word-organised data memory (DMEM). It accepts byte, halfword and word loads and stores with byte addresses, then sequences the DMEM read/write strobes so that read and write are never asserted together. Sub-word stores are done as read-modify-write. Loads are returned sign- or zero-extended, and misaligned requests are flagged without touching memory.

## Interface
- No parameters. DMEM depth is fixed at 1024 words; address bits above [11:2] pass through unchecked.
- One clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- lsu_req  input  1  request valid; sampled only when in IDLE
- lsu_we  input  1  1 = store, 0 = load
- lsu_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- lsu_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- lsu_addr  input  32  byte address
- lsu_wdata  input  32  store data, right-justified
- lsu_busy  output  1  high while state != IDLE
- lsu_done  output  1  one-cycle completion pulse
- lsu_rdata  output  32  extended load data; valid while lsu_done is high and held until the next load completes
- lsu_misaligned  output  1  one-cycle pulse for a rejected request
- DMEM_address  output  32  word index {2'b00, addr[31:2]}
- DMEM_data_in  output  32  write word to DMEM
- DMEM_mem_write  output  1  DMEM write strobe
- DMEM_mem_read  output  1  DMEM read strobe
- DMEM_data_out  input  32  DMEM read data; combinational from DMEM_address

## Operation
- Byte lanes are little-endian: lane k = word bits [8k+7:8k], selected by addr[1:0].
- Acceptance: in IDLE with lsu_req = 1, the unit latches addr, size, we, unsigned and wdata. Upstream may change its inputs after acceptance.
- A request is misaligned when:
  - size = 01 and addr[0] = 1, or
  - size = 10 and addr[1:0] != 0, or
  - size = 11.
- Misaligned request: no DMEM access, state stays IDLE, lsu_misaligned = 1 in the next cycle, lsu_done stays 0.
- States and transitions:
  - IDLE → RD on a load.
  - IDLE → WR on a word store.
  - IDLE → RMW_RD on a byte or halfword store.
  - RD: DMEM_mem_read = 1. At the clock edge, extract the addressed lane(s), extend to 32 bits into lsu_rdata, → IDLE and pulse lsu_done.
  - WR: DMEM_mem_write = 1 with DMEM_data_in = latched wdata → IDLE and pulse lsu_done.
  - RMW_RD: DMEM_mem_read = 1. At the clock edge, capture DMEM_data_out into the merge register → RMW_WR.
  - RMW_WR: DMEM_mem_write = 1 with DMEM_data_in = merge word, where wdata[7:0] (byte) or wdata[15:0] (halfword) replaces the addressed lane(s) → IDLE and pulse lsu_done.
- Strobe rules:
  - DMEM_mem_read and DMEM_mem_write are decoded from the registered state only, so they are glitch-free and mutually exclusive.
  - Both strobes are 0 in IDLE.
  - DMEM_address and DMEM_data_in are registered and stable for the whole strobe cycle.
- lsu_req asserted while busy is ignored and is not queued. A new request may be accepted in the same cycle lsu_done is high.
- Reset, asserted at any time including mid-RMW:
  - state = IDLE and strobes drop immediately.
  - No lsu_done is issued. An interrupted RMW leaves memory unmodified.
- Reset values: lsu_busy 0, lsu_done 0, lsu_rdata 0, lsu_misaligned 0, DMEM_address 0, DMEM_data_in 0, DMEM_mem_write 0, DMEM_mem_read 0.

## Timing
- Cycle 0 is the accept edge.
- Load: RD in cycle 1, lsu_done and lsu_rdata in cycle 2. Latency is 2 cycles.
- Word store: WR in cycle 1, lsu_done in cycle 2.
- Sub-word store: RMW_RD in cycle 1, RMW_WR in cycle 2, lsu_done in cycle 3.
- Misaligned: lsu_misaligned in cycle 1.
- Sustained back-to-back throughput: one load or word store every 2 cycles, one sub-word store every 3 cycles.
- lsu_busy rises in cycle 1 and falls in the lsu_done cycle.

## Test plan
- Word round trip: store word 0xDEADBEEF at 0x40, then load word at 0x40 → DMEM_address = 0x10, lsu_rdata = 0xDEADBEEF, lsu_done in cycle 2 of each access.
- Byte RMW: word 0x11223344 at 0x40, store byte 0xAA at 0x42 → strobe sequence read, write (3 cycles); a following word load returns 0x11AA3344.
- Extension: load byte at 0x42 with unsigned = 0 → 0xFFFFFFAA; with unsigned = 1 → 0x000000AA. Load halfword at 0x42 with unsigned = 0 → 0x000011AA.
- Misaligned: halfword load at 0x41, and word store at 0x42 → lsu_misaligned pulses in cycle 1, no strobe asserted, memory unchanged, lsu_done never asserted.
- Reset mid-RMW: assert rst_n = 0 during RMW_RD → strobes drop immediately, no lsu_done, the target word is unchanged on reload.
- Busy/protocol: pulse lsu_req during RD → request ignored. Read and write strobes are never high together (assertion held over a random 1000-request run checked against a reference memory).
